// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory, stalling memory states on a ready handshake.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 on ready
// DECODE    | read registers, ALUOut <= OldPC + imm (branch/jump target)
// MEMADR    | ALUOut <= rs1 + imm
// MEMREAD   | load from ALUOut, wait for ready
// MEMWB     | write loaded data to rd
// MEMWRITE  | store to ALUOut, strobe held until ready
// EXECR     | R-type ALU op on rs1, rs2
// EXECI     | I-type ALU op on rs1, imm
// ALUWB     | write ALUOut to rd
// BEQ       | compare rs1/rs2, branch to ALUOut if zero
// JAL       | PC <= ALUOut, ALUOut <= OldPC+4
// ILLEGAL   | halted on unsupported opcode until reset
module multicycle_control_unit #(
  parameter int ALUC_W   = 3,
  parameter int EN_SHIFT = 0,
  parameter int MEM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic              RegWrite,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              instr_done,
  output logic              illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  logic [3:0] state, state_nxt;
  logic [3:0] funct_code, alu_code;
  logic       ready;
  logic       pcw, memw, irw, regw, done;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (ready) state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // funct7b5 only selects sub for R-type; addi with instr[30]=1 stays add
  always_comb begin
    funct_code = ALU_ADD;
    case (funct3)
      3'b000:  funct_code = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  funct_code = ALU_AND;
      3'b110:  funct_code = ALU_OR;
      3'b100:  funct_code = ALU_XOR;
      3'b010:  funct_code = ALU_SLT;
      3'b001:  if (EN_SHIFT != 0) funct_code = ALU_SLL;
      3'b101:  if (EN_SHIFT != 0) funct_code = funct7b5 ? ALU_SRA : ALU_SRL;
      default: funct_code = ALU_ADD;
    endcase
  end

  always_comb begin
    pcw       = 1'b0;
    memw      = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_code  = ALU_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = ready;
        pcw       = ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
        done   = ready;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        alu_code = funct_code;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        alu_code = funct_code;
      end
      S_ALUWB: begin
        regw = 1'b1;
        done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_code = ALU_SUB;
        pcw      = zero;
        done     = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Reset is asynchronous, so strobes are also masked combinationally while it is held
  assign PCWrite    = pcw  & ~reset;
  assign IRWrite    = irw  & ~reset;
  assign MemWrite   = memw & ~reset;
  assign RegWrite   = regw & ~reset;
  assign instr_done = done & ~reset;
  assign ALUControl = ALUC_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed and randomized instruction sequences for multicycle_control_unit,
// checked cycle by cycle against an instruction-level phase model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  int tests = 0;
  int fails = 0;

  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_ILLEGAL} phase_t;

  typedef struct packed {
    logic       pcw, adr, memw, irw;
    logic [1:0] ress, srca, srcb, imm;
    logic       regw;
    logic [3:0] aluc;
    logic       done, ill;
  } outs_t;

  multicycle_control_unit #(.ALUC_W(4), .EN_SHIFT(1), .MEM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [3:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 4'd1 : 4'd0;
      3'b111:  return 4'd2;
      3'b110:  return 4'd3;
      3'b100:  return 4'd4;
      3'b010:  return 4'd5;
      3'b001:  return 4'd6;
      3'b101:  return f7 ? 4'd8 : 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic outs_t expect_outs(input phase_t p, input logic rdy, input logic z,
                                        input logic [6:0] o, input logic [2:0] f3, input logic f7);
    outs_t e;
    e = '0;
    e.imm = imm_of(o);
    case (p)
      P_FETCH:    begin e.srcb = 2'b10; e.ress = 2'b10; e.irw = rdy; e.pcw = rdy; end
      P_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      P_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      P_MEMREAD:  e.adr = 1'b1;
      P_MEMWB:    begin e.ress = 2'b01; e.regw = 1'b1; e.done = 1'b1; end
      P_MEMWRITE: begin e.adr = 1'b1; e.memw = 1'b1; e.done = rdy; end
      P_EXECR:    begin e.srca = 2'b10; e.aluc = alu_of(o, f3, f7); end
      P_EXECI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = alu_of(o, f3, f7); end
      P_ALUWB:    begin e.regw = 1'b1; e.done = 1'b1; end
      P_BEQ:      begin e.srca = 2'b10; e.aluc = 4'd1; e.pcw = z; e.done = 1'b1; end
      P_JAL:      begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
      default:    e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
         RegWrite, ALUControl, instr_done, illegal};
    return o;
  endfunction

  task automatic check(input string tag, input outs_t e);
    outs_t o;
    o = observed();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_reset(input string tag);
    outs_t e;
    e = expect_outs(P_FETCH, mem_ready, zero, op, funct3, funct7b5);
    e.pcw = 1'b0;
    e.irw = 1'b0;
    check(tag, e);
  endtask

  // r: 0/1 forces mem_ready, 2 drives it randomly (state must ignore it)
  task automatic step(input phase_t p, input int r);
    @(negedge clk);
    mem_ready = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
    zero      = 1'($urandom_range(0, 1));
    #1;
    check(p.name(), expect_outs(p, mem_ready, zero, op, funct3, funct7b5));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int sf, input int sm);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < sf; i++) step(P_FETCH, 0);
    step(P_FETCH, 1);
    step(P_DECODE, 2);
    case (o)
      7'b0000011: begin
        step(P_MEMADR, 2);
        for (int i = 0; i < sm; i++) step(P_MEMREAD, 0);
        step(P_MEMREAD, 1);
        step(P_MEMWB, 2);
      end
      7'b0100011: begin
        step(P_MEMADR, 2);
        for (int i = 0; i < sm; i++) step(P_MEMWRITE, 0);
        step(P_MEMWRITE, 1);
      end
      7'b0110011: begin step(P_EXECR, 2); step(P_ALUWB, 2); end
      7'b0010011: begin step(P_EXECI, 2); step(P_ALUWB, 2); end
      7'b1100011: step(P_BEQ, 2);
      7'b1101111: begin step(P_JAL, 2); step(P_ALUWB, 2); end
      default: for (int i = 0; i < 20; i++) step(P_ILLEGAL, 2);
    endcase
  endtask

  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check_reset("reset_hold");
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;

    // lw 0x00402283 with single-cycle memory
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0);
    // sw stalled three cycles in MEMWRITE
    run_instr(7'b0100011, 3'b010, 1'b0, 1, 3);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0);
    run_instr(7'b0010011, 3'b000, 1'b1, 0, 0);
    run_instr(7'b0110011, 3'b101, 1'b1, 2, 0);
    run_instr(7'b0010011, 3'b001, 1'b0, 0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++)
      run_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));

    // reset asserted between edges while a store is stalled
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    step(P_FETCH, 1);
    step(P_DECODE, 2);
    step(P_MEMADR, 2);
    step(P_MEMWRITE, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset("reset_mid_store");
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("fetch_after_reset", expect_outs(P_FETCH, 1'b0, zero, op, funct3, funct7b5));
    run_instr(7'b0010011, 3'b110, 1'b0, 0, 0);

    // unsupported opcode halts until reset
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset("reset_from_illegal");
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    run_instr(7'b0110011, 3'b111, 1'b0, 1, 0);
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
